phase_frame_receiver: RTL
=========================

Name: phase_frame_receiver

Overview:
- Consumer for the PR3 result stream: accepts valid/sop/eop framed packets of (freq, phaseA, phaseB) bins.
- Checks framing and computes the per-bin phase difference phaseB - phaseA.
- Holds complete frames in a two-bank ping-pong buffer.
- Replays the frames to a downstream host or serialiser over a ready/valid stream with sop/eop. Sits directly on the PR3 source_* outputs in the clk40 domain.

Parameters:
- FRAME, 16, bins per packet; a legal packet is exactly FRAME beats.
- ABITS, $clog2(FRAME), bin index width.
- CNTW, 16, width of the saturating status counters.

Ports:
- clk40  in  1  system clock, 40 MHz.
- reset  in  1  synchronous, active-high reset.
- sink_valid  in  1  input beat valid; no backpressure, always accepted.
- sink_sop  in  1  first beat of a packet.
- sink_eop  in  1  last beat of a packet.
- sink_freq  in  24  unsigned bin frequency (Hz).
- sink_phaseA  in  16  signed phase, channel A.
- sink_phaseB  in  16  signed phase, channel B.
- rd_valid  out  1  output beat valid.
- rd_ready  in  1  downstream accepts the beat.
- rd_sop  out  1  first beat of an output frame.
- rd_eop  out  1  last beat of an output frame.
- rd_index  out  ABITS  bin index within the frame.
- rd_freq  out  24  stored frequency.
- rd_dphase  out  16  signed phaseB - phaseA, wrapped to 16 bits.
- frame_err_cnt  out  CNTW  saturating count of framing errors.
- drop_cnt  out  CNTW  saturating count of good frames dropped because both banks were full.

Behaviour:
- Reset: synchronous, active-high, clk40 only. Clears both bank-full flags, the write FSM (to IDLE), the read FSM, rd_valid, rd_sop, rd_eop, rd_index, rd_freq, rd_dphase and both counters, all to 0. Reset mid-frame discards the partial frame and any stored frames. RAM contents need no reset.
- Arithmetic: dphase = sink_phaseB - sink_phaseA in 17 bits, truncated to the low 16 bits (two's-complement wrap, no saturation). Computed at write time; the RAM stores {freq, dphase} (40 bits) per bin.
- Write FSM states:
  - IDLE:
    - valid&sop: select the write bank (lowest-numbered non-full bank, bank 0 preferred), write bin 0, cnt=1, go RECV. If FRAME==1 and eop is also set, commit immediately and stay IDLE.
    - valid&sop with both banks full: go DISCARD, drop_cnt++ when that frame ends correctly.
    - valid&!sop: beat ignored, frame_err_cnt++.
  - RECV:
    - valid&sop: framing error, frame_err_cnt++; restart the frame at bin 0 in the same bank.
    - valid&eop with cnt==FRAME-1: write the bin and commit. Commit sets the bank-full flag on the next edge. Go IDLE.
    - valid&eop with cnt<FRAME-1: short packet, frame_err_cnt++, bank not committed, go IDLE.
    - valid&!eop with cnt==FRAME-1: long packet, frame_err_cnt++, go DISCARD.
  - DISCARD:
    - Ignore beats until valid&eop, then go IDLE.
    - valid&sop in DISCARD is handled as in IDLE (new frame).
    - drop_cnt increments only for correctly framed frames that were dropped because both banks were full.
- Read side:
  - Banks are drained in commit order (ordering bit, 1 flop).
  - Read FSM: RIDLE -> PRIME (1-cycle synchronous RAM read) -> STREAM.
  - First rd_valid occurs 2 cycles after the commit edge.
  - rd_* are registered and held stable while rd_valid&!rd_ready.
  - Sustains one beat per cycle while rd_ready=1 (prefetch/skid register required).
  - rd_sop on index 0; rd_eop on index FRAME-1.
  - Bank-full flag clears on the edge at which the eop beat is accepted. The other full bank, if any, starts PRIME on the following cycle.
- Simultaneous events:
  - Commit to bank X in the same cycle as release of bank Y is legal; both take effect.
  - Write never targets a bank being read, because that bank is still flagged full.
- Counters saturate at 2^CNTW-1.

Test Plan:
- Clean frame, FRAME=16: bin k has freq=5000*k, phaseA=100, phaseB=-100, rd_ready=1. Required: 16 beats, rd_dphase=0xFF38 (-200), rd_sop at idx 0, rd_eop at idx 15, first rd_valid 2 cycles after the commit edge, both counters 0.
- Wrap: phaseA=-32000, phaseB=32000 -> rd_dphase=-1536 (0xFA00). Second case: phaseA=32767, phaseB=-32768 -> rd_dphase=1.
- Framing errors:
  - eop at beat 10 -> no output, frame_err_cnt=1.
  - Stray valid without sop -> frame_err_cnt=2.
  - 17-beat packet -> frame_err_cnt=3, no output.
  - A following clean frame is output normally.
- Backpressure: rd_ready=0, send 3 clean frames -> drop_cnt=1. Then rd_ready=1 -> exactly 32 beats: frame 1 data then frame 2 data, in order.
- rd_ready toggling every cycle during a 16-beat frame -> 16 accepted beats, no duplicates, no gaps in rd_index, rd_* stable while stalled.
- Reset asserted for 1 cycle at beat 8 of an input frame while a stored frame is mid-readout -> rd_valid=0 the next cycle, counters 0, no further output until a new clean frame.

Source files
------------

// File: rtl/phase_frame_receiver.sv
// Receives framed (freq, phaseA, phaseB) packets, stores {freq, phaseB-phaseA}
// into a two-bank ping-pong RAM and replays complete frames over ready/valid.
module phase_frame_receiver #(
    parameter int FRAME = 16,
    parameter int ABITS = $clog2(FRAME),
    parameter int CNTW  = 16
) (
    input  logic             clk40,
    input  logic             reset,
    input  logic             sink_valid,
    input  logic             sink_sop,
    input  logic             sink_eop,
    input  logic [23:0]      sink_freq,
    input  logic [15:0]      sink_phaseA,
    input  logic [15:0]      sink_phaseB,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             rd_sop,
    output logic             rd_eop,
    output logic [ABITS-1:0] rd_index,
    output logic [23:0]      rd_freq,
    output logic [15:0]      rd_dphase,
    output logic [CNTW-1:0]  frame_err_cnt,
    output logic [CNTW-1:0]  drop_cnt
);

    localparam logic [ABITS-1:0] LAST = ABITS'(FRAME - 1);
    localparam logic [ABITS-1:0] ONE  = ABITS'(1);
    localparam int               WORDS = 2 ** (ABITS + 1);

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DISCARD} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_PRIME, R_STREAM} rd_state_t;

    logic [39:0] mem [WORDS];

    wr_state_t        wr_state_reg, wr_state_next;
    logic             wr_bank_reg, wr_bank_next;
    logic [ABITS-1:0] cnt_reg, cnt_next;
    logic             track_reg, track_next;
    logic [1:0]       full_reg;
    logic             head_reg;
    logic             start_ok, ram_we, commit, err_inc, drop_inc;
    logic [ABITS-1:0] ram_widx;
    logic [15:0]      dphase;
    logic             both_full;

    rd_state_t        rd_state_reg;
    logic             rd_bank_reg;
    logic [ABITS-1:0] fetch_idx_reg;
    logic             fetch_done_reg;
    logic             q_valid_reg;
    logic [ABITS-1:0] q_idx_reg;
    logic [39:0]      ram_q;
    logic             ren, raddr_bank;
    logic [ABITS-1:0] raddr_idx;
    logic             advance, eop_accept;

    // A 16-bit subtract gives exactly the low 16 bits of the 17-bit difference.
    assign dphase     = sink_phaseB - sink_phaseA;
    assign both_full  = &full_reg;
    assign advance    = !rd_valid || rd_ready;
    assign eop_accept = rd_valid && rd_ready && rd_eop;

    always_comb begin
        wr_state_next = wr_state_reg;
        wr_bank_next  = wr_bank_reg;
        cnt_next      = cnt_reg;
        track_next    = track_reg;
        start_ok      = 1'b0;
        ram_we        = 1'b0;
        ram_widx      = cnt_reg;
        commit        = 1'b0;
        err_inc       = 1'b0;
        drop_inc      = 1'b0;
        if (sink_valid && sink_sop) begin
            if (wr_state_reg == W_RECV) begin
                err_inc  = 1'b1;
                start_ok = 1'b1;
            end else if (!both_full) begin
                wr_bank_next = full_reg[0];
                start_ok     = 1'b1;
            end
            cnt_next = ONE;
            if (start_ok) begin
                ram_we   = 1'b1;
                ram_widx = '0;
                if (sink_eop) begin
                    if (FRAME == 1) commit  = 1'b1;
                    else            err_inc = 1'b1;
                    wr_state_next = W_IDLE;
                end else begin
                    wr_state_next = W_RECV;
                end
            end else begin
                // No free bank: follow the frame so a well-formed one counts as a drop.
                track_next = 1'b1;
                if (sink_eop) begin
                    if (FRAME == 1) drop_inc = 1'b1;
                    wr_state_next = W_IDLE;
                end else begin
                    wr_state_next = W_DISCARD;
                end
            end
        end else if (sink_valid) begin
            case (wr_state_reg)
                W_RECV: begin
                    if (cnt_reg == LAST) begin
                        if (sink_eop) begin
                            ram_we        = 1'b1;
                            commit        = 1'b1;
                            wr_state_next = W_IDLE;
                        end else begin
                            err_inc       = 1'b1;
                            track_next    = 1'b0;
                            wr_state_next = W_DISCARD;
                        end
                    end else begin
                        ram_we = 1'b1;
                        if (sink_eop) begin
                            err_inc       = 1'b1;
                            wr_state_next = W_IDLE;
                        end else begin
                            cnt_next = cnt_reg + ONE;
                        end
                    end
                end
                W_DISCARD: begin
                    if (sink_eop) begin
                        if (track_reg && cnt_reg == LAST) drop_inc = 1'b1;
                        wr_state_next = W_IDLE;
                    end else if (cnt_reg == LAST) begin
                        track_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + ONE;
                    end
                end
                default: err_inc = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk40) begin
        if (ram_we) mem[{wr_bank_next, ram_widx}] <= {sink_freq, dphase};
    end

    always_ff @(posedge clk40) begin
        if (reset) begin
            wr_state_reg  <= W_IDLE;
            wr_bank_reg   <= 1'b0;
            cnt_reg       <= '0;
            track_reg     <= 1'b0;
            full_reg      <= '0;
            head_reg      <= 1'b0;
            frame_err_cnt <= '0;
            drop_cnt      <= '0;
        end else begin
            wr_state_reg <= wr_state_next;
            wr_bank_reg  <= wr_bank_next;
            cnt_reg      <= cnt_next;
            track_reg    <= track_next;
            // head_reg names the oldest full bank; commit and release never touch the same bank.
            if (commit) begin
                full_reg[wr_bank_next] <= 1'b1;
                if (!full_reg[~wr_bank_next]) head_reg <= wr_bank_next;
            end
            if (eop_accept) begin
                full_reg[rd_bank_reg] <= 1'b0;
                head_reg              <= ~rd_bank_reg;
            end
            if (err_inc && frame_err_cnt != {CNTW{1'b1}})
                frame_err_cnt <= frame_err_cnt + CNTW'(1);
            if (drop_inc && drop_cnt != {CNTW{1'b1}})
                drop_cnt <= drop_cnt + CNTW'(1);
        end
    end

    // RAM output register doubles as the skid stage in front of the rd_* register.
    always_comb begin
        ren        = 1'b0;
        raddr_bank = rd_bank_reg;
        raddr_idx  = fetch_idx_reg;
        case (rd_state_reg)
            R_IDLE: begin
                if (full_reg[head_reg]) begin
                    ren        = 1'b1;
                    raddr_bank = head_reg;
                    raddr_idx  = '0;
                end
            end
            default: begin
                if (eop_accept) begin
                    if (full_reg[~rd_bank_reg]) begin
                        ren        = 1'b1;
                        raddr_bank = ~rd_bank_reg;
                        raddr_idx  = '0;
                    end
                end else if (!fetch_done_reg && (!q_valid_reg || advance)) begin
                    ren = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk40) begin
        if (ren) ram_q <= mem[{raddr_bank, raddr_idx}];
    end

    always_ff @(posedge clk40) begin
        if (reset) begin
            rd_state_reg   <= R_IDLE;
            rd_bank_reg    <= 1'b0;
            fetch_idx_reg  <= '0;
            fetch_done_reg <= 1'b1;
            q_valid_reg    <= 1'b0;
            q_idx_reg      <= '0;
            rd_valid       <= 1'b0;
            rd_sop         <= 1'b0;
            rd_eop         <= 1'b0;
            rd_index       <= '0;
            rd_freq        <= '0;
            rd_dphase      <= '0;
        end else begin
            if (advance) begin
                rd_valid <= q_valid_reg;
                if (q_valid_reg) begin
                    rd_index  <= q_idx_reg;
                    rd_freq   <= ram_q[39:16];
                    rd_dphase <= ram_q[15:0];
                    rd_sop    <= (q_idx_reg == '0);
                    rd_eop    <= (q_idx_reg == LAST);
                end
            end
            if (ren) begin
                q_valid_reg <= 1'b1;
                q_idx_reg   <= raddr_idx;
                rd_bank_reg <= raddr_bank;
                if (raddr_idx == LAST) begin
                    fetch_done_reg <= 1'b1;
                end else begin
                    fetch_done_reg <= 1'b0;
                    fetch_idx_reg  <= raddr_idx + ONE;
                end
            end else if (q_valid_reg && advance) begin
                q_valid_reg <= 1'b0;
            end
            case (rd_state_reg)
                R_IDLE:  if (ren) rd_state_reg <= R_PRIME;
                R_PRIME: rd_state_reg <= R_STREAM;
                default: if (eop_accept) rd_state_reg <= ren ? R_PRIME : R_IDLE;
            endcase
        end
    end

endmodule
